// File: rtl/sub6bit_serial_if.sv
// Request/result bundle for the bit-serial subtractor.
// The requester drives the master side; the subtractor drives the slave side.
interface sub6bit_serial_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output start, in1, in2,
    input  busy, done, diff, bout, zero
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, diff, bout, zero
  );
endinterface

// File: rtl/sub6bit_serial.sv
// Bit-serial unsigned subtractor: in1 - in2, one bit per clock, LSB first.
// A single full-subtractor cell plus a registered borrow; start/busy/done handshake.
module sub6bit_serial #(
  parameter int unsigned WIDTH = 6
) (
  input logic              clk,
  input logic              rst_n,
  sub6bit_serial_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  // Full-subtractor cell on the current LSBs
  assign d_bit      = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          a_d     = bus.in1;
          b_d     = bus.in2;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        diff_d = diff_shift;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          bout_d  = br_next;
          zero_d  = (diff_shift == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_sub6bit_serial.sv
// Bench for sub6bit_serial: directed vector table, multi-cycle corner cases and
// random operands, all checked through a scoreboard of expected results.
module tb_sub6bit_serial;

  localparam int unsigned WIDTH = 6;

  typedef struct {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    int               acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   n_done;
  exp_t sb[$];

  sub6bit_serial_if #(.WIDTH(WIDTH)) bus ();

  sub6bit_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive a request at the current negedge; queue an expectation if it will be accepted.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
    exp_t e;
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    if (!bus.busy && rst_n) begin
      e.diff = ed;
      e.bout = eb;
      e.zero = ez;
      e.acc  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic issue_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} - {1'b0, b};
    issue(a, b, t[WIDTH-1:0], a < b, t[WIDTH-1:0] == '0);
  endtask

  // Step negedges until done is seen; leaves the caller at the done negedge.
  task automatic run_to_done(output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", int'(bus.diff), int'(e.diff));
        check("bout", int'(bus.bout), int'(e.bout));
        check("zero", int'(bus.zero), int'(e.zero));
        check("latency", cyc - e.acc, WIDTH);
      end
    end
  end

  vec_t vecs[6];
  int   bc;
  int   done_before;

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    n_done    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;

    vecs[0] = '{in1: 6'd37, in2: 6'd12, diff: 6'd25, bout: 1'b0, zero: 1'b0};
    vecs[1] = '{in1: 6'd12, in2: 6'd37, diff: 6'd39, bout: 1'b1, zero: 1'b0};
    vecs[2] = '{in1: 6'd0,  in2: 6'd1,  diff: 6'd63, bout: 1'b1, zero: 1'b0};
    vecs[3] = '{in1: 6'd20, in2: 6'd20, diff: 6'd0,  bout: 1'b0, zero: 1'b1};
    vecs[4] = '{in1: 6'd63, in2: 6'd0,  diff: 6'd63, bout: 1'b0, zero: 1'b0};
    vecs[5] = '{in1: 6'd9,  in2: 6'd9,  diff: 6'd0,  bout: 1'b0, zero: 1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_diff", int'(bus.diff), 0);
    check("rst_bout", int'(bus.bout), 0);
    check("rst_zero", int'(bus.zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; first entry also checks busy width and result hold
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].in1, vecs[i].in2, vecs[i].diff, vecs[i].bout, vecs[i].zero);
      run_to_done(bc);
      if (i == 0) begin
        check("busy_cycles", bc, WIDTH);
        repeat (2) @(negedge clk);
        check("hold_diff", int'(bus.diff), 25);
        check("hold_done", int'(bus.done), 0);
      end
      @(negedge clk);
    end

    // Start while busy is ignored; start in the done cycle is accepted
    issue(6'd37, 6'd12, 6'd25, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    issue(6'd5, 6'd1, 6'd4, 1'b0, 1'b0);
    check("ignored_start", sb.size(), 1);
    run_to_done(bc);
    issue(6'd5, 6'd1, 6'd4, 1'b0, 1'b0);
    check("done_cycle_accept", sb.size(), 2);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_done", int'(bus.done), 0);
    run_to_done(bc);
    @(negedge clk);

    // Reset mid-operation discards the result with no done pulse
    issue(6'd50, 6'd7, 6'd43, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_diff", int'(bus.diff), 0);
    check("mid_rst_bout", int'(bus.bout), 0);
    rst_n = 1'b1;
    done_before = n_done;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", n_done - done_before, 0);
    issue(6'd9, 6'd9, 6'd0, 1'b0, 1'b1);
    run_to_done(bc);
    @(negedge clk);

    // Random operands, alternating idle gaps and back-to-back issue
    for (int i = 0; i < 1000; i++) begin
      issue_model(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      run_to_done(bc);
      if (i % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
